// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic ops, two-cycle half-width carry chain for adds,
// an extra negate cycle for ADDNN, and a registered result behind a valid/ready handshake.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             Illegal
);

  localparam int H = WIDTH / 2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LO   = 3'd1;
  localparam logic [2:0] ST_HI   = 3'd2;
  localparam logic [2:0] ST_NEG  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [3:0]       OP_ADDNN  = 4'b1011;
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cin_q, cin_d;
  logic             carry_q, carry_d;
  logic [H-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;
  logic             res_valid_q, res_valid_d;

  logic             op_ready_s;
  logic             accept_s;
  logic [H:0]       lo_sum_s;
  logic [H:0]       hi_ext_s;
  logic [WIDTH-1:0] full_s;
  logic             ovf_add_s;
  logic             ovf_nn_s;
  logic [WIDTH-1:0] logic_res_s;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0:    r = ~a;
      3'd1:    r = ~b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a & b);
      3'd6:    r = ~(a | b);
      3'd7:    r = ~(a ^ b);
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  assign op_ready_s = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && res_ready));
  assign accept_s   = op_valid && op_ready_s;

  // Half-width adders; the high half is sign-extended by one bit so the exact sum's sign survives.
  always_comb begin
    lo_sum_s    = {1'b0, x_q[H-1:0]} + {1'b0, y_q[H-1:0]} + {{H{1'b0}}, cin_q};
    hi_ext_s    = {x_q[WIDTH-1], x_q[WIDTH-1:H]} + {y_q[WIDTH-1], y_q[WIDTH-1:H]}
                + {{H{1'b0}}, carry_q};
    full_s      = {hi_ext_s[H-1:0], lo_q};
    ovf_add_s   = hi_ext_s[H] ^ hi_ext_s[H-1];
    // Negating the sum fits only when the exact sum lies in (-2^(W-1), 2^(W-1)].
    if (full_s == MOST_NEG) begin
      ovf_nn_s = hi_ext_s[H];
    end else begin
      ovf_nn_s = hi_ext_s[H] ^ full_s[WIDTH-1];
    end
    logic_res_s = logic_op(Operation[2:0], A, B);
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    cin_d      = cin_q;
    carry_d    = carry_q;
    lo_d       = lo_q;
    sum_d      = sum_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_LO: begin
        lo_d    = lo_sum_s[H-1:0];
        carry_d = lo_sum_s[H];
        state_d = ST_HI;
      end
      ST_HI: begin
        if (op_q == OP_ADDNN) begin
          sum_d   = full_s;
          ovf_d   = ovf_nn_s;
          state_d = ST_NEG;
        end else begin
          result_d   = full_s;
          zero_d     = (full_s == ZERO_W);
          overflow_d = ovf_add_s;
          illegal_d  = 1'b0;
          state_d    = ST_DONE;
        end
      end
      ST_NEG: begin
        result_d   = ~sum_q + ONE_W;
        zero_d     = ((~sum_q + ONE_W) == ZERO_W);
        overflow_d = ovf_q;
        illegal_d  = 1'b0;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Acceptance overrides the DONE->IDLE step so back-to-back ops carry no bubble.
    if (accept_s) begin
      op_d = Operation;
      if (Operation[3] == 1'b0) begin
        result_d   = logic_res_s;
        zero_d     = (logic_res_s == ZERO_W);
        overflow_d = 1'b0;
        illegal_d  = 1'b0;
        state_d    = ST_DONE;
      end else if (Operation[2] == 1'b1) begin
        result_d   = ZERO_W;
        zero_d     = 1'b1;
        overflow_d = 1'b0;
        illegal_d  = 1'b1;
        state_d    = ST_DONE;
      end else begin
        case (Operation[1:0])
          2'b01: begin
            x_d = A;  y_d = ~B; cin_d = 1'b1;
          end
          2'b10: begin
            x_d = ~A; y_d = B;  cin_d = 1'b1;
          end
          default: begin
            x_d = A;  y_d = B;  cin_d = 1'b0;
          end
        endcase
        state_d = ST_LO;
      end
    end else begin
      op_d = op_q;
    end

    res_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 4'b0000;
      x_q         <= {WIDTH{1'b0}};
      y_q         <= {WIDTH{1'b0}};
      cin_q       <= 1'b0;
      carry_q     <= 1'b0;
      lo_q        <= {H{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      ovf_q       <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cin_q       <= cin_d;
      carry_q     <= carry_d;
      lo_q        <= lo_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign op_ready  = op_ready_s;
  assign res_valid = res_valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Overflow  = overflow_q;
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: hand-computed vectors, latency, reset abort and handshake hold.
module tb_alu_exec;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  Operation;
  logic [31:0] A;
  logic [31:0] B;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        Illegal;

  int total;
  int bad;

  alu_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .Operation(Operation), .A(A), .B(B), .res_valid(res_valid), .res_ready(res_ready),
    .Result(Result), .Zero(Zero), .Overflow(Overflow), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op from IDLE with res_ready=1, measure latency and check the result fields.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_z,
                        input logic exp_o, input logic exp_i, input int exp_lat);
    int lat;
    res_ready = 1'b1;
    check_val({tag, "_rdy"}, {31'd0, op_ready}, 32'd1);
    op_valid  = 1'b1;
    Operation = op;
    A = a;
    B = b;
    @(posedge clk); #1;
    op_valid  = 1'b0;
    A = ~a;
    B = ~b;
    Operation = 4'b0011;
    lat = 1;
    while (!res_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_res"}, Result, exp_res);
    check_val({tag, "_flags"}, {29'd0, Zero, Overflow, Illegal}, {29'd0, exp_z, exp_o, exp_i});
    @(posedge clk); #1;
    check_val({tag, "_drop"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    op_valid = 1'b0;
    Operation = 4'b0000;
    A = 32'd0;
    B = 32'd0;
    res_ready = 1'b1;
    #12;
    check_val("rst_state", {27'd0, op_ready, res_valid, Zero, Overflow, Illegal}, 32'd0);
    check_val("rst_result", Result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("and",    4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1);
    run_op("nota",   4'b0000, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1);
    run_op("nor",    4'b0110, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
    run_op("xnor",   4'b0111, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1);
    run_op("carry",  4'b1000, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0, 3);
    run_op("addovf", 4'b1000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 3);
    run_op("subz",   4'b1001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 3);
    run_op("subovf", 4'b1001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 3);
    run_op("rsub",   4'b1010, 32'h00000005, 32'h00000003, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 3);
    run_op("neg",    4'b1011, 32'h00000001, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 4);
    run_op("negmin", 4'b1011, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 4);
    run_op("negfit", 4'b1011, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b0, 4);
    run_op("illegal",4'b1101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1);

    // Reset while the add is in its high-half cycle.
    op_valid = 1'b1;
    Operation = 4'b1000;
    A = 32'h00000010;
    B = 32'h00000020;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("abort_valid", {31'd0, res_valid}, 32'd0);
    check_val("abort_result", Result, 32'd0);
    check_val("abort_ready", {31'd0, op_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_ready", {31'd0, op_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("no_stale", {31'd0, res_valid}, 32'd0);
    end

    // Hold the result for five cycles, then release with a logic op queued.
    res_ready = 1'b0;
    op_valid = 1'b1;
    Operation = 4'b1000;
    A = 32'h0000FFFF;
    B = 32'h00000001;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("hold_valid0", {31'd0, res_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("hold_result", Result, 32'h00010000);
      check_val("hold_state", {30'd0, res_valid, op_ready}, 32'd2);
    end
    op_valid = 1'b1;
    Operation = 4'b0011;
    A = 32'h0F0F0000;
    B = 32'h000000F0;
    res_ready = 1'b1;
    #1;
    check_val("b2b_ready", {31'd0, op_ready}, 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    check_val("b2b_valid", {31'd0, res_valid}, 32'd1);
    check_val("b2b_result", Result, 32'h0F0F00F0);
    @(posedge clk); #1;
    check_val("b2b_drop", {31'd0, res_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
